mix_columns_seq: RTL

//  Sequential, handshaked MixColumns / InvMixColumns stage for the RAMBAM redundant-representation AES datapath.

---
 rtl/mix_columns_seq_if.sv | 22 ++
 rtl/mix_columns_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mix_columns_seq_if.sv
// rtl/mix_columns_seq_if.sv - block handshake bundle for the sequential MixColumns stage
interface mix_columns_seq_if #(
    parameter int d = 0
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic                    inv_i;
    logic [3:0][3:0][0:7+d]  state_vec_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [3:0][3:0][0:7+d]  state_vec_o;

    modport master (
        output in_valid_i, inv_i, state_vec_i, out_ready_i,
        input  in_ready_o, out_valid_o, state_vec_o
    );

    modport slave (
        input  in_valid_i, inv_i, state_vec_i, out_ready_i,
        output in_ready_o, out_valid_o, state_vec_o
    );
endinterface

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - column-serial MixColumns/InvMixColumns on redundant (8+d)-bit bytes
module mix_columns_seq #(
    parameter int                  d              = 0,
    parameter logic [0:7+d][0:7+d] L_two          = 64'h40201088_84028180,
    parameter int                  COLS_PER_CYCLE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mix_columns_seq_if.slave  bus
);
    localparam int W = 8 + d;

    typedef logic [0:W-1]      byte_t;
    typedef byte_t [3:0]       col_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_t                   fsm_q;
    logic [1:0]             col_cnt;
    logic                   inv_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [3:0][3:0][0:W-1] state_q;
    logic [3:0][3:0][0:W-1] mixed;
    col_t                   col_w;
    logic [1:0]             idx_w;

    function automatic byte_t mul_l(input byte_t x);
        byte_t y;
        for (int r = 0; r < W; r++) begin
            y[r] = ^(L_two[r] & x);
        end
        return y;
    endfunction

    // Inverse reuses the forward network after folding in the {04} terms.
    function automatic col_t mix_col(input col_t a_in, input logic inv);
        col_t  a;
        col_t  res;
        byte_t u;
        byte_t v;
        byte_t t;
        a = a_in;
        if (inv) begin
            u = mul_l(mul_l(a[0] ^ a[2]));
            v = mul_l(mul_l(a[1] ^ a[3]));
            a[0] = a[0] ^ u;
            a[2] = a[2] ^ u;
            a[1] = a[1] ^ v;
            a[3] = a[3] ^ v;
        end
        t = a[0] ^ a[1] ^ a[2] ^ a[3];
        for (int r = 0; r < 4; r++) begin
            res[r] = a[r] ^ t ^ mul_l(a[r] ^ a[(r + 1) % 4]);
        end
        return res;
    endfunction

    always_comb begin
        mixed = state_q;
        col_w = '0;
        idx_w = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            idx_w = col_cnt + 2'(k);
            for (int r = 0; r < 4; r++) begin
                col_w[r] = state_q[r][idx_w];
            end
            col_w = mix_col(col_w, inv_q);
            for (int r = 0; r < 4; r++) begin
                mixed[r][idx_w] = col_w[r];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q       <= IDLE;
            col_cnt     <= '0;
            inv_q       <= 1'b0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        state_q    <= bus.state_vec_i;
                        inv_q      <= bus.inv_i;
                        col_cnt    <= '0;
                        in_ready_q <= 1'b0;
                        fsm_q      <= BUSY;
                    end
                end
                BUSY: begin
                    state_q <= mixed;
                    if (col_cnt == 2'(4 - COLS_PER_CYCLE)) begin
                        col_cnt     <= '0;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        col_cnt <= col_cnt + 2'(COLS_PER_CYCLE);
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.state_vec_o = state_q;
endmodule
